// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, FSM states
// and opcode classification helpers.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Opcodes the external ALU actually implements.
  function automatic logic isLegalOp(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Only the arithmetic ops drive a meaningful CarryOut; for the others
  // the ALU carry line is left over from whatever ran before.
  function automatic logic carryIsMeaningful(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant. The pointer names the requester that wins
// when both ask at once; a lone requester always wins.
module alu_rr_arb2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_ptr,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  // One-hot grant, or no grant at all while disabled.
  always_comb begin
    o_grant = 2'b00;
    if (i_enable) begin
      if (i_valid0 && (!i_valid1 || !i_ptr)) begin
        o_grant = 2'b01;
      end else if (i_valid1) begin
        o_grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters. A command
// is latched into the ALU operand registers, the ALU settles for one cycle,
// and the result is held on the granted requester's response port until
// that requester takes it.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [2:0]       i_req0_op,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [WIDTH-1:0] o_rsp0_result,
  output logic             o_rsp0_carry,
  output logic             o_rsp0_zero,
  output logic             o_rsp0_err,

  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic [2:0]       i_req1_op,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp1_result,
  output logic             o_rsp1_carry,
  output logic             o_rsp1_zero,
  output logic             o_rsp1_err,

  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [2:0]       o_alu_op,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_carry,
  input  logic             i_alu_zero,

  output logic             o_busy
);

  state_t           r_state;
  logic             r_ptr;
  logic             r_grantId;
  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic [2:0]       r_aluOp;

  logic             r_rsp0Valid;
  logic [WIDTH-1:0] r_rsp0Result;
  logic             r_rsp0Carry;
  logic             r_rsp0Zero;
  logic             r_rsp0Err;
  logic             r_rsp1Valid;
  logic [WIDTH-1:0] r_rsp1Result;
  logic             r_rsp1Carry;
  logic             r_rsp1Zero;
  logic             r_rsp1Err;

  logic             w_arbEnable;
  logic [1:0]       w_grant;
  logic             w_accept;
  logic             w_rspTaken;
  logic [WIDTH-1:0] w_capResult;
  logic             w_capCarry;
  logic             w_capZero;
  logic             w_capErr;

  // Commands are only considered while idle, and never while reset is
  // held so that no ready can leak out during reset.
  assign w_arbEnable = (r_state == S_IDLE) && !reset;
  assign w_accept    = |w_grant;
  assign w_rspTaken  = r_grantId ? i_rsp1_ready : i_rsp0_ready;

  alu_rr_arb2 u_arb (
    .i_valid0 (i_req0_valid),
    .i_valid1 (i_req1_valid),
    .i_ptr    (r_ptr),
    .i_enable (w_arbEnable),
    .o_grant  (w_grant)
  );

  // Response to capture at the end of EXEC: pass ALU outputs for legal ops
  // (masking the stale carry of logic/compare ops), canned error otherwise.
  always_comb begin
    w_capResult = '0;
    w_capCarry  = 1'b0;
    w_capZero   = 1'b1;
    w_capErr    = 1'b1;
    if (isLegalOp(r_aluOp)) begin
      w_capResult = i_alu_result;
      w_capCarry  = carryIsMeaningful(r_aluOp) && i_alu_carry;
      w_capZero   = i_alu_zero;
      w_capErr    = 1'b0;
    end
  end

  // Controller FSM: IDLE accepts one command, EXEC lets the ALU settle and
  // captures its outputs, RESP holds the response until it is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= 1'b0;
      r_grantId    <= 1'b0;
      r_aluA       <= '0;
      r_aluB       <= '0;
      r_aluOp      <= 3'b000;
      r_rsp0Valid  <= 1'b0;
      r_rsp0Result <= '0;
      r_rsp0Carry  <= 1'b0;
      r_rsp0Zero   <= 1'b0;
      r_rsp0Err    <= 1'b0;
      r_rsp1Valid  <= 1'b0;
      r_rsp1Result <= '0;
      r_rsp1Carry  <= 1'b0;
      r_rsp1Zero   <= 1'b0;
      r_rsp1Err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_aluA    <= w_grant[1] ? i_req1_a  : i_req0_a;
            r_aluB    <= w_grant[1] ? i_req1_b  : i_req0_b;
            r_aluOp   <= w_grant[1] ? i_req1_op : i_req0_op;
            r_grantId <= w_grant[1];
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_grantId) begin
            r_rsp1Valid  <= 1'b1;
            r_rsp1Result <= w_capResult;
            r_rsp1Carry  <= w_capCarry;
            r_rsp1Zero   <= w_capZero;
            r_rsp1Err    <= w_capErr;
          end else begin
            r_rsp0Valid  <= 1'b1;
            r_rsp0Result <= w_capResult;
            r_rsp0Carry  <= w_capCarry;
            r_rsp0Zero   <= w_capZero;
            r_rsp0Err    <= w_capErr;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_rspTaken) begin
            r_rsp0Valid <= 1'b0;
            r_rsp1Valid <= 1'b0;
            r_ptr       <= ~r_grantId;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req0_ready  = w_grant[0];
  assign o_req1_ready  = w_grant[1];
  assign o_alu_a       = r_aluA;
  assign o_alu_b       = r_aluB;
  assign o_alu_op      = r_aluOp;
  assign o_busy        = (r_state != S_IDLE);

  assign o_rsp0_valid  = r_rsp0Valid;
  assign o_rsp0_result = r_rsp0Result;
  assign o_rsp0_carry  = r_rsp0Carry;
  assign o_rsp0_zero   = r_rsp0Zero;
  assign o_rsp0_err    = r_rsp0Err;
  assign o_rsp1_valid  = r_rsp1Valid;
  assign o_rsp1_result = r_rsp1Result;
  assign o_rsp1_carry  = r_rsp1Carry;
  assign o_rsp1_zero   = r_rsp1Zero;
  assign o_rsp1_err    = r_rsp1Err;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU attached and a
// per-requester scoreboard of expected responses.
module tb_alu_share_ctrl;

  typedef struct packed {
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0Valid, req0Ready, rsp0Valid, rsp0Ready;
  logic [31:0] req0A, req0B, rsp0Result;
  logic [2:0]  req0Op;
  logic        rsp0Carry, rsp0Zero, rsp0Err;
  logic        req1Valid, req1Ready, rsp1Valid, rsp1Ready;
  logic [31:0] req1A, req1B, rsp1Result;
  logic [2:0]  req1Op;
  logic        rsp1Carry, rsp1Zero, rsp1Err;
  logic [31:0] aluA, aluB, aluResult;
  logic [2:0]  aluOp;
  logic        aluCarry, aluZero, busy;

  rsp_t q0[$];
  rsp_t q1[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req0_valid  (req0Valid),
    .o_req0_ready  (req0Ready),
    .i_req0_a      (req0A),
    .i_req0_b      (req0B),
    .i_req0_op     (req0Op),
    .o_rsp0_valid  (rsp0Valid),
    .i_rsp0_ready  (rsp0Ready),
    .o_rsp0_result (rsp0Result),
    .o_rsp0_carry  (rsp0Carry),
    .o_rsp0_zero   (rsp0Zero),
    .o_rsp0_err    (rsp0Err),
    .i_req1_valid  (req1Valid),
    .o_req1_ready  (req1Ready),
    .i_req1_a      (req1A),
    .i_req1_b      (req1B),
    .i_req1_op     (req1Op),
    .o_rsp1_valid  (rsp1Valid),
    .i_rsp1_ready  (rsp1Ready),
    .o_rsp1_result (rsp1Result),
    .o_rsp1_carry  (rsp1Carry),
    .o_rsp1_zero   (rsp1Zero),
    .o_rsp1_err    (rsp1Err),
    .o_alu_a       (aluA),
    .o_alu_b       (aluB),
    .o_alu_op      (aluOp),
    .i_alu_result  (aluResult),
    .i_alu_carry   (aluCarry),
    .i_alu_zero    (aluZero),
    .o_busy        (busy)
  );

  // Behavioural ALU; the carry line is deliberately left high for logic and
  // compare ops, and unimplemented opcodes produce garbage.
  always_comb begin
    aluResult = 32'hdeadbeef;
    aluCarry  = 1'b1;
    case (aluOp)
      3'b000: aluResult = aluA & aluB;
      3'b001: aluResult = aluA | aluB;
      3'b010: {aluCarry, aluResult} = {1'b0, aluA} + {1'b0, aluB};
      3'b110: {aluCarry, aluResult} = {1'b0, aluA} - {1'b0, aluB};
      3'b111: aluResult = (aluA < aluB) ? 32'd1 : 32'd0;
      default: ;
    endcase
    aluZero = (aluResult == 32'd0);
  end

  // Hard stop in case a step never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic rsp_t refModel(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] op);
    rsp_t r;
    logic [32:0] wide;
    r = '0;
    case (op)
      3'b000: r.result = a & b;
      3'b001: r.result = a | b;
      3'b010: begin wide = {1'b0, a} + {1'b0, b}; r.result = wide[31:0]; r.carry = wide[32]; end
      3'b110: begin wide = {1'b0, a} - {1'b0, b}; r.result = wide[31:0]; r.carry = wide[32]; end
      3'b111: r.result = (a < b) ? 32'd1 : 32'd0;
      default: begin r.err = 1'b1; end
    endcase
    r.zero = r.err ? 1'b1 : (r.result == 32'd0);
    return r;
  endfunction

  function automatic logic getReady(input int id);
    return (id == 1) ? req1Ready : req0Ready;
  endfunction

  function automatic logic getRspValid(input int id);
    return (id == 1) ? rsp1Valid : rsp0Valid;
  endfunction

  function automatic rsp_t getRsp(input int id);
    if (id == 1) return {rsp1Result, rsp1Carry, rsp1Zero, rsp1Err};
    return {rsp0Result, rsp0Carry, rsp0Zero, rsp0Err};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] op);
    if (id == 1) begin
      req1Valid = 1'b1; req1A = a; req1B = b; req1Op = op;
      q1.push_back(refModel(a, b, op));
    end else begin
      req0Valid = 1'b1; req0A = a; req0B = b; req0Op = op;
      q0.push_back(refModel(a, b, op));
    end
  endtask

  task automatic dropValid(input int id);
    if (id == 1) req1Valid = 1'b0;
    else         req0Valid = 1'b0;
  endtask

  task automatic setRspReady(input int id, input logic v);
    if (id == 1) rsp1Ready = v;
    else         rsp0Ready = v;
  endtask

  // Waits for ready, lets the accepting edge pass, drops valid and checks
  // the EXEC cycle that follows. Returns at negedge+1 inside EXEC.
  task automatic waitAccept(input int id);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (getReady(id)) ok = 1'b1;
      else @(negedge clk);
    end
    checkOutput("acceptTimeout", 64'(ok), 64'd1);
    if (ok) begin
      @(negedge clk);
      dropValid(id);
      #1;
      checkOutput("execBusy", 64'(busy), 64'd1);
      checkOutput("execNoRspYet", 64'(getRspValid(id)), 64'd0);
    end else begin
      dropValid(id);
      if (id == 1) void'(q1.pop_back());
      else         void'(q0.pop_back());
    end
  endtask

  // Waits for the response, compares it with the scoreboard, holds ready
  // low for holdCycles while checking stability, then completes it.
  task automatic checkRsp(input int id, input int holdCycles);
    bit          ok;
    int          lat;
    rsp_t        exp, obs;
    logic [31:0] heldA;
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (getRspValid(id)) begin ok = 1'b1; lat = i; end
      else begin @(negedge clk); #1; end
    end
    checkOutput("rspTimeout", 64'(ok), 64'd1);
    if (ok) begin
      checkOutput("rspLatency", 64'(lat), 64'd1);
      obs   = getRsp(id);
      heldA = aluA;
      exp   = 'x;
      if (id == 1 && q1.size() > 0) exp = q1.pop_front();
      if (id == 0 && q0.size() > 0) exp = q0.pop_front();
      checkOutput("rspResult", 64'(obs.result), 64'(exp.result));
      checkOutput("rspCarry",  64'(obs.carry),  64'(exp.carry));
      checkOutput("rspZero",   64'(obs.zero),   64'(exp.zero));
      checkOutput("rspErr",    64'(obs.err),    64'(exp.err));
      checkOutput("rspOtherQuiet", 64'(getRspValid(1 - id)), 64'd0);
      for (int k = 0; k < holdCycles; k++) begin
        @(negedge clk); #1;
        checkOutput("holdValid",      64'(getRspValid(id)), 64'd1);
        checkOutput("holdData",       64'(getRsp(id)), 64'(obs));
        checkOutput("holdAluA",       64'(aluA), 64'(heldA));
        checkOutput("holdOtherReady", 64'(getReady(1 - id)), 64'd0);
      end
      setRspReady(id, 1'b1);
      @(negedge clk);
      setRspReady(id, 1'b0);
      #1;
      checkOutput("rspDropped",  64'(getRspValid(id)), 64'd0);
      checkOutput("rspDataKept", 64'(getRsp(id)), 64'(obs));
    end
  endtask

  task automatic checkAllClear(input string tag);
    checkOutput({tag, "Alu"},   {aluA, aluB}, 64'd0);
    checkOutput({tag, "AluOp"}, 64'(aluOp), 64'd0);
    checkOutput({tag, "Ctl"},   64'({busy, rsp0Valid, rsp1Valid, req0Ready, req1Ready}), 64'd0);
    checkOutput({tag, "Rsp0"},  64'({rsp0Result, rsp0Carry, rsp0Zero, rsp0Err}), 64'd0);
    checkOutput({tag, "Rsp1"},  64'({rsp1Result, rsp1Carry, rsp1Zero, rsp1Err}), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    req0Valid = 1'b0; req0A = '0; req0B = '0; req0Op = '0; rsp0Ready = 1'b0;
    req1Valid = 1'b0; req1A = '0; req1B = '0; req1Op = '0; rsp1Ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkAllClear("reset");
    reset = 1'b0;
    @(negedge clk);

    // Lone req0 AND: result 0, zero, stale carry masked
    applyStimulus(0, 32'ha5a5a5a5, 32'h5a5a5a5a, 3'b000);
    waitAccept(0);
    checkRsp(0, 0);

    // Lone req1 SUB of equal values, leaves req0 favoured
    applyStimulus(1, 32'ha5a5a5a5, 32'ha5a5a5a5, 3'b110);
    waitAccept(1);
    checkRsp(1, 0);

    // Simultaneous pair: req0 ADD with carry-out wins, then req1 OR
    applyStimulus(0, 32'hffffffff, 32'h00000001, 3'b010);
    applyStimulus(1, 32'ha5a5a5a5, 32'h5a5a5a5a, 3'b001);
    #1;
    checkOutput("pairReady", 64'({req1Ready, req0Ready}), 64'b01);
    waitAccept(0);
    checkRsp(0, 0);
    waitAccept(1);
    checkRsp(1, 0);

    // Pair again: req0 unsigned SLT first, then illegal opcode on req1
    applyStimulus(0, 32'h5a5a5a5a, 32'ha5a5a5a5, 3'b111);
    applyStimulus(1, 32'h13572468, 32'h0000ffff, 3'b011);
    waitAccept(0);
    checkRsp(0, 0);
    waitAccept(1);
    checkOutput("illegalAluOp", 64'(aluOp), 64'd3);
    checkOutput("illegalAluA",  64'(aluA), 64'h13572468);
    checkRsp(1, 0);

    // Response stalled five cycles while req1 waits
    applyStimulus(0, 32'h12340000, 32'h00005678, 3'b001);
    waitAccept(0);
    applyStimulus(1, 32'h7fffffff, 32'h00000003, 3'b010);
    #1;
    checkOutput("waitReady1", 64'(req1Ready), 64'd0);
    checkRsp(0, 5);
    waitAccept(1);
    checkRsp(1, 0);

    // Lone req0 SUB with borrow, leaving req1 favoured
    applyStimulus(0, 32'h00000001, 32'h00000002, 3'b110);
    waitAccept(0);
    checkRsp(0, 0);

    // Pair now grants req1 first
    applyStimulus(0, 32'h12345678, 32'h11111111, 3'b010);
    applyStimulus(1, 32'h0f0f0000, 32'h000000f0, 3'b001);
    #1;
    checkOutput("pairReadyFlip", 64'({req1Ready, req0Ready}), 64'b10);
    waitAccept(1);
    checkRsp(1, 0);
    waitAccept(0);
    checkRsp(0, 0);

    // Reset during EXEC aborts the op and restores req0 priority
    applyStimulus(0, 32'h00000005, 32'h00000003, 3'b010);
    waitAccept(0);
    reset = 1'b1;
    #1;
    checkAllClear("midReset");
    void'(q0.pop_back());
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("noRspAfterReset", 64'({rsp1Valid, rsp0Valid}), 64'd0);
    applyStimulus(0, 32'h00000005, 32'h00000003, 3'b010);
    applyStimulus(1, 32'h000000ff, 32'h0000000f, 3'b000);
    #1;
    checkOutput("postResetArb", 64'({req1Ready, req0Ready}), 64'b01);
    waitAccept(0);
    checkRsp(0, 0);
    waitAccept(1);
    checkRsp(1, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
